// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   IMEM_DEPTH_WORDS : default RAM depth in 32-bit words (power of two)
//   IMEM_NOP         : instruction returned when no valid response is held
//   imem_state_e     : responder FSM states {LOAD, RUN}
//   imem_rsp_meta_t  : registered response metadata (data comes from the RAM)
package imem_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 1024;
  localparam int unsigned IMEM_XLEN        = 32;
  localparam logic [IMEM_XLEN-1:0] IMEM_NOP = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  // from_ram selects the RAM read register as the data source; otherwise NOP.
  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic                 from_ram;
    logic [IMEM_XLEN-1:0] pc;
  } imem_rsp_meta_t;

endpackage : imem_pkg

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous instruction RAM with registered read.
//   clk      : clock
//   we_i     : write enable (wdata_i -> mem[addr_i])
//   re_i     : read enable (mem[addr_i] -> rdata_o on next edge)
//   addr_i   : word index shared by read and write
//   wdata_i  : write word
//   rdata_o  : registered read word; holds while re_i is low
// Contents are not reset; the read register holds its value when not enabled.
module imem_ram
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS),
  localparam int unsigned DATA_W      = IMEM_XLEN
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage array and read register; we and re are never both set by the owner.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : imem_ram

// File: rtl/imem_resp.sv
// imem_resp: instruction-memory responder between IF logic and program storage.
// Boot-loads the RAM in LOAD, then serves one fetch per cycle with 1-cycle
// latency in RUN. Stall holds the response, flush clears it (flush wins).
//   clk, rst_n                : clock, async active-low reset
//   fetch_req/addr/stall/flush: fetch request interface from IF
//   fetch_vld/data/pc/err     : registered fetch response
//   ld_vld/addr/data/last     : boot-load write port
//   ld_rdy                    : high in LOAD
//   run                       : high in RUN
// Build option: IMEM_ADDR_CHK_EN enables misaligned / out-of-range address
// errors; without it the word index wraps and fetch_err stays 0.
module imem_resp
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              fetch_stall,
  input  logic              fetch_flush,
  output logic              fetch_vld,
  output logic [31:0]       fetch_data,
  output logic [31:0]       fetch_pc,
  output logic              fetch_err,
  input  logic              ld_vld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_rdy,
  output logic              run
);

  imem_state_e    state_q;
  logic           ld_rdy_q;
  logic           run_q;
  imem_rsp_meta_t rsp_q;

  logic [ADDR_W-1:0] fetch_idx_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic              accept_c;
  logic              addr_bad_c;
  logic              ram_we_c;
  logic              ram_re_c;
  logic [31:0]       ram_rdata;

  // Word index of the fetch byte address.
  assign fetch_idx_c = fetch_addr[ADDR_W+1:2];

  // A request is taken only in RUN and only when not stalled.
  assign accept_c = (state_q == RUN) & fetch_req & ~fetch_stall;

`ifdef IMEM_ADDR_CHK_EN
  // Misaligned byte offset or any index bit beyond the RAM depth.
  assign addr_bad_c = (fetch_addr[1:0] != 2'b00)
                    | ((fetch_addr >> (ADDR_W + 2)) != 32'd0);
`else
  assign addr_bad_c = 1'b0;
`endif

  // LOAD and RUN are exclusive, so the single RAM port is never read and
  // written in the same cycle.
  assign ram_we_c   = (state_q == LOAD) & ld_vld;
  assign ram_re_c   = accept_c & ~addr_bad_c;
  assign ram_addr_c = (state_q == LOAD) ? ld_addr : fetch_idx_c;

  imem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .re_i    (ram_re_c),
    .addr_i  (ram_addr_c),
    .wdata_i (ld_data),
    .rdata_o (ram_rdata)
  );

  // Mode FSM and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      ld_rdy_q <= 1'b1;
      run_q    <= 1'b0;
      rsp_q    <= '0;
    end else if (state_q == LOAD) begin
      rsp_q <= '0;
      if (ld_vld & ld_last) begin
        state_q  <= RUN;
        ld_rdy_q <= 1'b0;
        run_q    <= 1'b1;
      end
    end else begin
      if (accept_c) begin
        // Covers flush+req as well: the request is the redirect target.
        rsp_q.vld      <= 1'b1;
        rsp_q.err      <= addr_bad_c;
        rsp_q.from_ram <= ~addr_bad_c;
        rsp_q.pc       <= fetch_addr;
      end else if (fetch_flush | ~fetch_stall) begin
        rsp_q <= '0;
      end
      // Stall without flush: hold rsp_q; RAM read register also holds.
    end
  end

  // Data mux select is a register, so outputs depend only on state.
  assign fetch_vld  = rsp_q.vld;
  assign fetch_err  = rsp_q.err;
  assign fetch_pc   = rsp_q.pc;
  assign fetch_data = rsp_q.from_ram ? ram_rdata : IMEM_NOP;
  assign ld_rdy     = ld_rdy_q;
  assign run        = run_q;

endmodule : imem_resp
